r_id_ordering_unit: RTL
=======================

Name: r_id_ordering_unit

Overview:
- Sits directly downstream of the incoming R response FIFO. It takes AXI R beats tagged with internal transaction IDs, which can arrive out of order.
- It releases them to the AXI master in strict allocation order and restores each transaction's original ARID.
- The AR-side ID remapper tells the block each tag allocation in issue order. The block returns freed tags to the remapper once the final beat of a transaction has been delivered.

Parameters:
- ID_WIDTH, 4, width of internal tag and of original ID; NUM_TAGS = 2**ID_WIDTH.
- DATA_WIDTH, 64, R data width.
- RESP_WIDTH, 2, R resp width.
- MAX_BEATS, 4, per-tag beat storage; upstream never issues longer bursts.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- alloc_valid  input  1  new tag allocated by remapper.
- alloc_ready  output  1  order queue can accept allocation.
- alloc_tag  input  ID_WIDTH  internal tag issued on AR.
- alloc_orig_id  input  ID_WIDTH  original ARID to restore.
- r_in  r_if.receiver  -  R beats from response FIFO; id carries the internal tag.
- r_out  r_if.sender  -  reordered R beats toward the master; id carries the original ID.
- tag_free_valid  output  1  one-cycle pulse: tag released.
- tag_free_tag  output  ID_WIDTH  released tag.
- err_unexpected  output  1  sticky: beat dropped for a non-inflight tag, or after that tag's last beat.
- err_overflow  output  1  sticky: beat dropped because the tag already holds MAX_BEATS beats.
- err_dup_alloc  output  1  sticky: allocation of an already-inflight tag ignored.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset clears:
  - order queue, all inflight/last_seen bits, per-tag wr_cnt, head rd_idx;
  - r_out.valid=0, tag_free_valid=0, all err_* = 0, alloc_ready=1.
  - Reset mid-burst discards all stored beats.
- Order queue:
  - circular FIFO of NUM_TAGS tags; wrap-around pointers plus count;
  - alloc_ready = ~full;
  - push on alloc_valid & alloc_ready.
  - Push records inflight[tag]=1, orig_id[tag], wr_cnt=0, last_seen=0.
  - If inflight[alloc_tag] is already set: no push, err_dup_alloc set.
  - Exception: the tag is being released in the same cycle. Release has priority, and the allocation is then accepted.
- Beat storage:
  - NUM_TAGS x MAX_BEATS entries of {data, resp, last}.
  - Widths: wr_cnt and rd_idx are $clog2(MAX_BEATS+1) bits.
- Input side:
  - r_in.ready = 1 at all times outside reset; there is no backpressure.
  - On r_in.valid, with tag t = r_in.id:
    - if inflight[t] & ~last_seen[t] & wr_cnt[t] < MAX_BEATS: write slot wr_cnt[t], increment wr_cnt, set last_seen if r_in.last;
    - else if ~inflight[t] | last_seen[t]: drop, set err_unexpected;
    - else: drop, set err_overflow.
- Output side, with head h = oldest queue entry:
  - r_out.valid = ~empty & (rd_idx < wr_cnt[h]).
  - r_out.data/resp/last come combinationally from slot rd_idx of tag h; r_out.id = orig_id[h].
  - Payload is held stable while valid & ~ready.
- Latency: a beat written at clock edge N is visible on r_out at the earliest in the cycle after edge N. Head beats stream through (cut-through); a burst does not need to complete before forwarding starts.
- Pop on r_out.valid & r_out.ready:
  - non-last beat: rd_idx++;
  - last beat: clear inflight[h], last_seen[h], wr_cnt[h]; pop the queue; rd_idx=0.
  - On the following cycle, tag_free_valid=1 and tag_free_tag=h for exactly one cycle.
- Simultaneous events:
  - A write to the head tag in the same cycle as a head pop is legal; wr_cnt increments and rd_idx advances independently.
  - A push and a pop in the same cycle leave the queue count unchanged.
- Non-head tags accumulate beats while the head is blocked. Ordering is strict global allocation order, which is stricter than AXI per-ID order and legal.
- Control uses bitwise operators only.

Test Plan:
- In-order, single beats:
  - stimulus: alloc tag3/orig 0xA, then tag5/orig 0xB; R tag3 data 0x11 last, then tag5 data 0x22 last;
  - required: r_out (0xA, 0x11, last) then (0xB, 0x22, last); tag_free 3 then 5, each a single-cycle pulse.
- Out-of-order:
  - stimulus: alloc 3 then 5; R tag5 beats 0x50, 0x51(last) arrive first, then tag3 0x30(last);
  - required: r_out.valid stays 0 until the tag3 beat is stored; output order 0x30, 0x50, 0x51, with last only on 0x30 and 0x51.
- Backpressure:
  - stimulus: r_out.ready=0 for 10 cycles with the head beat valid;
  - required: valid, id, data, resp and last are all stable; r_in continues to accept beats for other tags.
- Overflow (MAX_BEATS=4):
  - stimulus: 5 non-last beats for tag2;
  - required: 5th beat dropped, err_overflow=1 and stays set; r_in.ready stays 1; the 4 stored beats are delivered.
- Unexpected and duplicate:
  - stimulus: R beat for never-allocated tag7; then a second alloc of an inflight tag;
  - required: beat dropped, err_unexpected=1, r_out.valid=0; duplicate alloc ignored, err_dup_alloc=1.
- Reset mid-burst:
  - stimulus: assert rst after 2 of 4 delivered beats;
  - required: immediately r_out.valid=0, alloc_ready=1, all err_* = 0; a new alloc/response pair afterwards completes normally.

Source files
------------

// File: rtl/r_id_ordering_unit_if.sv
// r_if: AXI read-data (R) channel bundle.
//   valid/ready : handshake
//   id          : internal tag (into the ordering unit) or original ARID (out of it)
//   data/resp   : beat payload
//   last        : final beat of the burst
// receiver modport consumes beats, sender modport produces them.
interface r_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2
);
  logic                  valid;
  logic                  ready;
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] data;
  logic [RESP_WIDTH-1:0] resp;
  logic                  last;

  modport receiver (input valid, id, data, resp, last, output ready);
  modport sender   (output valid, id, data, resp, last, input ready);
endinterface

// File: rtl/r_id_ordering_unit.sv
// r_id_ordering_unit: buffers out-of-order R beats per internal tag and
// releases them in strict tag-allocation order with the original ARID.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   alloc_valid/ready/tag/orig_id : tag allocations from the AR remapper, in issue order
//   r_in  (receiver)            : R beats tagged with the internal tag, never backpressured
//   r_out (sender)              : reordered R beats carrying the original ARID
//   tag_free_valid/tag          : one-cycle pulse returning a fully delivered tag
//   err_unexpected/overflow/dup_alloc : sticky error flags for dropped beats / ignored allocations
module r_id_ordering_unit #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2,
  parameter int MAX_BEATS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_valid,
  output logic                alloc_ready,
  input  logic [ID_WIDTH-1:0] alloc_tag,
  input  logic [ID_WIDTH-1:0] alloc_orig_id,
  r_if.receiver               r_in,
  r_if.sender                 r_out,
  output logic                tag_free_valid,
  output logic [ID_WIDTH-1:0] tag_free_tag,
  output logic                err_unexpected,
  output logic                err_overflow,
  output logic                err_dup_alloc
);
  localparam int NUM_TAGS = 1 << ID_WIDTH;
  localparam int CNT_W    = $clog2(MAX_BEATS + 1);
  localparam int SLOT_W   = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_BEATS);
  localparam logic [ID_WIDTH:0] FULL_CNT = (ID_WIDTH+1)'(NUM_TAGS);

  // Payload storage; never reset, validity is tracked by wr_cnt/rd_idx.
  logic [DATA_WIDTH-1:0] mem_data  [NUM_TAGS][MAX_BEATS];
  logic [RESP_WIDTH-1:0] mem_resp  [NUM_TAGS][MAX_BEATS];
  logic                  mem_last  [NUM_TAGS][MAX_BEATS];
  logic [ID_WIDTH-1:0]   queue_tag [NUM_TAGS];
  logic [ID_WIDTH-1:0]   orig_id   [NUM_TAGS];

  logic [ID_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ID_WIDTH:0]   count_q, count_d;
  logic [NUM_TAGS-1:0] inflight_q, inflight_d, last_seen_q, last_seen_d;
  logic [CNT_W-1:0]    wr_cnt_q [NUM_TAGS];
  logic [CNT_W-1:0]    wr_cnt_d [NUM_TAGS];
  logic [CNT_W-1:0]    rd_idx_q, rd_idx_d;
  logic                tag_free_valid_q, tag_free_valid_d;
  logic [ID_WIDTH-1:0] tag_free_tag_q, tag_free_tag_d;
  logic                err_unexpected_q, err_unexpected_d;
  logic                err_overflow_q, err_overflow_d;
  logic                err_dup_alloc_q, err_dup_alloc_d;

  logic [ID_WIDTH-1:0] head_tag, in_tag;
  logic [SLOT_W-1:0]   rd_slot, wr_slot;
  logic empty, full, out_valid, pop, pop_last;
  logic wr_room, wr_ok, drop_unexp, drop_ovf;
  logic alloc_fire, release_same, dup, push;

  assign head_tag = queue_tag[rd_ptr_q];
  assign in_tag   = r_in.id;
  assign rd_slot  = rd_idx_q[SLOT_W-1:0];
  assign wr_slot  = wr_cnt_q[in_tag][SLOT_W-1:0];

  assign empty     = ~|count_q;
  assign full      = (count_q == FULL_CNT);
  assign out_valid = ~empty & (rd_idx_q < wr_cnt_q[head_tag]);
  assign pop       = out_valid & r_out.ready;
  assign pop_last  = pop & mem_last[head_tag][rd_slot];

  assign wr_room    = (wr_cnt_q[in_tag] < MAX_CNT);
  assign wr_ok      = r_in.valid & inflight_q[in_tag] & ~last_seen_q[in_tag] & wr_room;
  assign drop_unexp = r_in.valid & (~inflight_q[in_tag] | last_seen_q[in_tag]);
  assign drop_ovf   = r_in.valid & inflight_q[in_tag] & ~last_seen_q[in_tag] & ~wr_room;

  // A tag finishing this cycle may be handed straight back out by the remapper.
  assign alloc_fire   = alloc_valid & alloc_ready;
  assign release_same = pop_last & (head_tag == alloc_tag);
  assign dup          = inflight_q[alloc_tag] & ~release_same;
  assign push         = alloc_fire & ~dup;

  assign alloc_ready = ~full;
  assign r_in.ready  = ~rst;

  assign r_out.valid = out_valid;
  assign r_out.id    = orig_id[head_tag];
  assign r_out.data  = mem_data[head_tag][rd_slot];
  assign r_out.resp  = mem_resp[head_tag][rd_slot];
  assign r_out.last  = mem_last[head_tag][rd_slot];

  assign tag_free_valid = tag_free_valid_q;
  assign tag_free_tag   = tag_free_tag_q;
  assign err_unexpected = err_unexpected_q;
  assign err_overflow   = err_overflow_q;
  assign err_dup_alloc  = err_dup_alloc_q;

  always_comb begin
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    inflight_d       = inflight_q;
    last_seen_d      = last_seen_q;
    wr_cnt_d         = wr_cnt_q;
    rd_idx_d         = rd_idx_q;
    tag_free_valid_d = pop_last;
    tag_free_tag_d   = head_tag;
    err_unexpected_d = err_unexpected_q | drop_unexp;
    err_overflow_d   = err_overflow_q | drop_ovf;
    err_dup_alloc_d  = err_dup_alloc_q | (alloc_fire & dup);
    count_d          = count_q + (ID_WIDTH+1)'(push) - (ID_WIDTH+1)'(pop_last);

    // A beat to the head tag and a head pop are independent: wr_cnt and rd_idx move separately.
    if (wr_ok) begin
      wr_cnt_d[in_tag] = wr_cnt_q[in_tag] + CNT_W'(1);
      if (r_in.last) last_seen_d[in_tag] = 1'b1;
    end

    if (pop_last) begin
      inflight_d[head_tag]  = 1'b0;
      last_seen_d[head_tag] = 1'b0;
      wr_cnt_d[head_tag]    = '0;
      rd_idx_d              = '0;
      rd_ptr_d              = rd_ptr_q + ID_WIDTH'(1);
    end else if (pop) begin
      rd_idx_d = rd_idx_q + CNT_W'(1);
    end

    // Applied after the release so a same-cycle re-allocation wins.
    if (push) begin
      inflight_d[alloc_tag]  = 1'b1;
      last_seen_d[alloc_tag] = 1'b0;
      wr_cnt_d[alloc_tag]    = '0;
      wr_ptr_d               = wr_ptr_q + ID_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      inflight_q       <= '0;
      last_seen_q      <= '0;
      rd_idx_q         <= '0;
      tag_free_valid_q <= 1'b0;
      tag_free_tag_q   <= '0;
      err_unexpected_q <= 1'b0;
      err_overflow_q   <= 1'b0;
      err_dup_alloc_q  <= 1'b0;
      for (int i = 0; i < NUM_TAGS; i++) wr_cnt_q[i] <= '0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      inflight_q       <= inflight_d;
      last_seen_q      <= last_seen_d;
      rd_idx_q         <= rd_idx_d;
      tag_free_valid_q <= tag_free_valid_d;
      tag_free_tag_q   <= tag_free_tag_d;
      err_unexpected_q <= err_unexpected_d;
      err_overflow_q   <= err_overflow_d;
      err_dup_alloc_q  <= err_dup_alloc_d;
      for (int i = 0; i < NUM_TAGS; i++) wr_cnt_q[i] <= wr_cnt_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_data[in_tag][wr_slot] <= r_in.data;
      mem_resp[in_tag][wr_slot] <= r_in.resp;
      mem_last[in_tag][wr_slot] <= r_in.last;
    end
    if (push) begin
      queue_tag[wr_ptr_q] <= alloc_tag;
      orig_id[alloc_tag]  <= alloc_orig_id;
    end
  end
endmodule
